// File: rtl/ingress_pkg.sv
// Shared register map and fixed read values for the host-to-channel staging buffer.
// Imported by the top level and the per-channel FIFO.
package ingress_pkg;

   localparam logic [2:0] ADDR_CTRL = 3'b000;
   localparam logic [2:0] ADDR_CH1  = 3'b001;
   localparam logic [2:0] ADDR_CH2  = 3'b010;
   localparam logic [2:0] ADDR_CH3  = 3'b011;
   localparam logic [2:0] ADDR_CNT1 = 3'b100;
   localparam logic [2:0] ADDR_CNT2 = 3'b101;
   localparam logic [2:0] ADDR_CNT3 = 3'b110;

   localparam logic [7:0] RD_BADADDR = 8'd252;
   localparam logic [7:0] RD_IDLE    = 8'd0;

endpackage

// File: rtl/ingress_fifo.sv
// One channel: DEPTH x 8 FIFO feeding a data/en output register, one word per cycle.
// A word held with en=1 stays put until rdy; pushes into a full FIFO are dropped and flag ovf.
module ingress_fifo
   import ingress_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          ena,
   input  logic          rdy,
   input  logic          ovf_clr,
   output logic [7:0]    data,
   output logic          en,
   output logic [CW-1:0] count,
   output logic          ovf
);

   localparam int AW = CW - 1;
   localparam logic [AW-1:0] P_ONE  = AW'(1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_data;
   logic          r_en;
   logic          r_ovf;

   logic w_load;
   logic w_push_ok;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts that push.
   assign w_load    = ena && (r_count != '0) && (!r_en || rdy);
   assign w_push_ok = push && ((r_count < C_FULL) || w_load);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_data   <= '0;
         r_en     <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + P_ONE;
         end
         if (w_load) begin
            r_rd_ptr <= r_rd_ptr + P_ONE;
            r_data   <= r_mem[r_rd_ptr];
            r_en     <= 1'b1;
         end else if (r_en && rdy) begin
            r_en <= 1'b0;
         end
         if (w_push_ok && !w_load) begin
            r_count <= r_count + C_ONE;
         end else if (!w_push_ok && w_load) begin
            r_count <= r_count - C_ONE;
         end
         // A drop in the same cycle as a clear leaves the flag set.
         if (push && !w_push_ok) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign data  = r_data;
   assign en    = r_en;
   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: rtl/ingress_buffer.sv
// Host write port into three channel FIFOs plus CTRL/occupancy readback; readdata is registered (1 cycle).
// Each channel streams independently under its own rdy back-pressure.
module ingress_buffer
   import ingress_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       chipselect,
   input  logic       write,
   input  logic       read,
   input  logic [2:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic [7:0] data1,
   output logic [7:0] data2,
   output logic [7:0] data3,
   output logic       en1,
   output logic       en2,
   output logic       en3,
   input  logic       rdy1,
   input  logic       rdy2,
   input  logic       rdy3
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [2:0]    r_ena;
   logic [7:0]    r_readdata;

   logic          w_wr;
   logic          w_rd;
   logic          w_ctrl_wr;
   logic          w_ovf_clr;
   logic [2:0]    w_push;
   logic [2:0]    w_ovf;
   logic [CW-1:0] w_cnt1;
   logic [CW-1:0] w_cnt2;
   logic [CW-1:0] w_cnt3;

   assign w_wr      = chipselect && write;
   assign w_rd      = chipselect && read;
   assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);
   assign w_ovf_clr = w_ctrl_wr && writedata[7];
   assign w_push[0] = w_wr && (address == ADDR_CH1);
   assign w_push[1] = w_wr && (address == ADDR_CH2);
   assign w_push[2] = w_wr && (address == ADDR_CH3);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ena <= 3'b000;
      end else if (w_ctrl_wr) begin
         r_ena <= writedata[2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= RD_IDLE;
      end else if (w_rd) begin
         case (address)
            ADDR_CTRL: r_readdata <= {2'b00, w_ovf, r_ena};
            ADDR_CNT1: r_readdata <= 8'(w_cnt1);
            ADDR_CNT2: r_readdata <= 8'(w_cnt2);
            ADDR_CNT3: r_readdata <= 8'(w_cnt3);
            default:   r_readdata <= RD_BADADDR;
         endcase
      end else begin
         r_readdata <= RD_IDLE;
      end
   end

   assign readdata = r_readdata;

   ingress_fifo #(.DEPTH(DEPTH), .CW(CW)) u_ch1 (
      .clk(clk), .reset(reset), .push(w_push[0]), .din(writedata),
      .ena(r_ena[0]), .rdy(rdy1), .ovf_clr(w_ovf_clr),
      .data(data1), .en(en1), .count(w_cnt1), .ovf(w_ovf[0])
   );

   ingress_fifo #(.DEPTH(DEPTH), .CW(CW)) u_ch2 (
      .clk(clk), .reset(reset), .push(w_push[1]), .din(writedata),
      .ena(r_ena[1]), .rdy(rdy2), .ovf_clr(w_ovf_clr),
      .data(data2), .en(en2), .count(w_cnt2), .ovf(w_ovf[1])
   );

   ingress_fifo #(.DEPTH(DEPTH), .CW(CW)) u_ch3 (
      .clk(clk), .reset(reset), .push(w_push[2]), .din(writedata),
      .ena(r_ena[2]), .rdy(rdy3), .ovf_clr(w_ovf_clr),
      .data(data3), .en(en3), .count(w_cnt3), .ovf(w_ovf[2])
   );

endmodule

// File: doc/ingress_buffer.md
# ingress_buffer

Host-to-pipeline staging buffer: the host writes bytes over the memory-mapped slave port into three per-channel FIFOs. The block streams each FIFO to its compute channel as data/enable pairs with a ready back-pressure handshake. It is the write-side counterpart of the result buffer, which collects channel results for host readback. It sits between the bus bridge and the three channel inputs (data1..data3, en1..en3).

## Interface
- DEPTH, 16, entries per channel FIFO; power of two, 2..128, so a fill count fits in readdata.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high.
- chipselect  input  1  slave select.
- write  input  1  write strobe; qualified by chipselect.
- read  input  1  read strobe; qualified by chipselect.
- address  input  3  register/port select.
- writedata  input  8  write data.
- readdata  output  8  registered read data.
- data1, data2, data3  output  8  channel data.
- en1, en2, en3  output  1  channel data valid.
- rdy1, rdy2, rdy3  input  1  channel consumer ready.

## Operation
- Write map (chipselect && write):
  - 3'b000 CTRL: writedata[2:0] set the stream enable for ch1..ch3. writedata[7]=1 clears all sticky overflow flags.
  - 3'b001 pushes writedata into the ch1 FIFO; 3'b010 into ch2; 3'b011 into ch3.
  - All other addresses are ignored.
- Read map (chipselect && read):
  - 3'b000 returns {2'b0, ovf[2:0], ena[2:0]}; ovf bit i is the sticky overflow flag for channel i+1.
  - 3'b100, 3'b101, 3'b110 return the FIFO occupancy of ch1, ch2, ch3, zero-extended.
  - Any other address returns 8'd252. When not selected, readdata = 8'd0.
- Push rule:
  - A push is accepted when count < DEPTH, or when a pop from the same FIFO occurs in the same cycle.
  - If neither holds, the byte is dropped, count is unchanged and ovf is set.
- Output stage, per channel: one output register (data, en).
  - Load when ena && count>0 && (!en || rdy). On load, pop the FIFO head into data and set en=1.
  - Clear en when en && rdy and no load occurs in that cycle.
  - While en=1 && rdy=0, data and en hold stable.
- Disabling a channel (ena=0) does not retract a word already held with en=1. That word completes its handshake; no further loads happen.
- Occupancy counts FIFO entries only, not the output register.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- CTRL write and a channel push in the same cycle are independent.
- A push and a pop on the same FIFO in the same cycle leave count unchanged.
- A clear of ovf and an overflow on the same cycle: the set wins.

## Timing
- Reset values:
  - readdata=0; data1..3=0; en1..3=0.
  - All ena and ovf bits = 0; all counts and pointers = 0.
  - Reset asserted mid-stream flushes all FIFOs and drops any held word on the next edge.
- Write at edge k updates FIFO and count at edge k.
- With an empty FIFO, an enabled channel and en=0: en=1 with the written byte after edge k+1.
- Back-to-back throughput is one word per cycle per channel while rdy=1 and count>0.
- Read latency is one cycle: readdata is valid after the edge that sampled the read.
- An occupancy read reflects state before that edge's push/pop.

## Structure
- Package ingress_pkg holds:
  - address constants ADDR_CTRL, ADDR_CH1..ADDR_CH3, ADDR_CNT1..ADDR_CNT3;
  - constants RD_BADADDR=8'd252 and RD_IDLE=8'd0.
- Sub-module ingress_fifo, instantiated three times, contains:
  - the DEPTH x 8 storage, pointers and count;
  - the push/overflow logic;
  - the output register with en/rdy handshake.
- It takes clk, reset, push, din, ena, rdy and ovf_clr. It outputs data, en, count and ovf.
- The top level holds address decode, the ena register and the readdata mux.

## Test plan
- After reset, push 8'hA5, 8'h3C to ch1 with ena=0 → en1 stays 0 and read 3'b100 returns 2. Write CTRL=8'h01 → en1=1 with data1=A5 after 1 cycle. Hold rdy1=1 → data1=3C on the next cycle, then en1=0.
- Hold rdy2=0 with en2=1, data2=8'h11 for 5 cycles → data2 and en2 stay stable. Raise rdy2 → the next FIFO word appears on the following cycle.
- Fill ch3 with DEPTH words (ena=0), then push 8'hFF → count=DEPTH, CTRL read bit5=1, 8'hFF absent from the stream. Write CTRL=8'h80 → bit5=0.
- With ch1 enabled and rdy1=1, keep the FIFO full while pushing each cycle → every pushed word emerges in order with no ovf. Run ≥2·DEPTH words to exercise pointer wrap.
- Push to all three channels on alternate cycles, all enabled → each channel outputs its own sequence independently. Read of 3'b111 returns 252; cycle with no chipselect returns 0.
- Assert reset while en1=1 and count1=5 → after the edge en1=0, count1=0 and ena=0. Later pushes are held until re-enabled.
